// File: rtl/mode_reg_bank.sv
// Parametrised register bank: one write port (load/inc/dec/clear) and two registered read ports.
// A wrap pulse flags increment or decrement roll-over.
module mode_reg_bank #(
   parameter int                 WIDTH     = 12,
   parameter int                 DEPTH     = 8,
   parameter bit                 BYPASS    = 1'b1,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0,
   localparam int                AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrEn,
   input  logic [AW-1:0]    wrAddr,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dataIn,
   input  logic [AW-1:0]    rdAddrA,
   input  logic [AW-1:0]    rdAddrB,
   output logic [WIDTH-1:0] dataOutA,
   output logic [WIDTH-1:0] dataOutB,
   output logic             zeroA,
   output logic             wrap
);

   localparam logic [AW:0]      DepthL  = (AW+1)'(DEPTH);
   localparam logic [WIDTH-1:0] AllOnes = '1;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] dataA_q, dataB_q, dataA_d, dataB_d;
   logic             zeroA_q, wrap_q, wrap_d;
   logic             wrValid;
   logic [WIDTH-1:0] oldVal, newVal;

   // Resolve the write: validity, pre-write value, op result and roll-over detection
   always_comb begin
      wrValid = wrEn && ({1'b0, wrAddr} < DepthL);
      oldVal  = wrValid ? regs_q[wrAddr] : '0;
      newVal  = oldVal;
      wrap_d  = 1'b0;
      case (op)
         2'b00: newVal = dataIn;
         2'b01: begin
            newVal = oldVal + 1'b1;
            wrap_d = wrValid && (oldVal == AllOnes);
         end
         2'b10: begin
            newVal = oldVal - 1'b1;
            wrap_d = wrValid && (oldVal == '0);
         end
         default: newVal = '0;
      endcase
   end

   function automatic logic [WIDTH-1:0] readPort(input logic [AW-1:0] addr);
      if ({1'b0, addr} >= DepthL)
         return '0;
      else if (BYPASS && wrValid && (addr == wrAddr))
         return newVal;
      else
         return regs_q[addr];
   endfunction

   // Read paths see either the post-write value (bypass) or the stored one
   always_comb begin
      dataA_d = readPort(rdAddrA);
      dataB_d = readPort(rdAddrB);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
         dataA_q <= RESET_VAL;
         dataB_q <= RESET_VAL;
         zeroA_q <= (RESET_VAL == '0);
         wrap_q  <= 1'b0;
      end else begin
         if (wrValid) regs_q[wrAddr] <= newVal;
         dataA_q <= dataA_d;
         dataB_q <= dataB_d;
         zeroA_q <= (dataA_d == '0);
         wrap_q  <= wrap_d;
      end
   end

   assign dataOutA = dataA_q;
   assign dataOutB = dataB_q;
   assign zeroA    = zeroA_q;
   assign wrap     = wrap_q;

endmodule

// File: doc/mode_reg_bank.md
Name: mode_reg_bank

Overview:
- Parametrised successor to the single-register storage element used in the processor datapath.
- Holds DEPTH registers of WIDTH bits each, with one write port and two registered read ports.
- The write port supports four operations: load, increment, decrement and clear, with a wrap indicator.
- Serves as the per-core scratch/pointer register bank. Counter-style registers (e.g. pointer registers) use the increment and decrement operations instead of an external adder.

Parameters:
- WIDTH, 12, data width of each register (>=2).
- DEPTH, 8, number of registers (>=2; need not be a power of two).
- BYPASS, 1, 1 = a read of an address being written in the same cycle returns the post-write value; 0 = returns the pre-write value.
- RESET_VAL, 0, value loaded into every register on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- wrEn  input  1  write-port enable.
- wrAddr  input  AW  target register; AW = max(1, $clog2(DEPTH)).
- op  input  2  write operation: 00 load, 01 increment, 10 decrement, 11 clear.
- dataIn  input  WIDTH  load data, used only when op=00.
- rdAddrA  input  AW  read address, port A.
- rdAddrB  input  AW  read address, port B.
- dataOutA  output  WIDTH  registered read data, port A.
- dataOutB  output  WIDTH  registered read data, port B.
- zeroA  output  1  registered; 1 when the value presented on dataOutA equals 0.
- wrap  output  1  registered one-cycle pulse on increment or decrement wrap-around.

Behaviour:
- Reset (rst=1 at posedge), dominant over all other inputs:
  - All DEPTH registers take RESET_VAL.
  - dataOutA and dataOutB take RESET_VAL.
  - zeroA = (RESET_VAL==0).
  - wrap = 0.
  - Reset asserted mid-sequence discards any write presented in that cycle.
- Write (wrEn=1, wrAddr<DEPTH), at posedge, for reg[wrAddr]:
  - op=00: reg <= dataIn.
  - op=01: reg <= reg+1, modulo 2^WIDTH.
  - op=10: reg <= reg-1, modulo 2^WIDTH.
  - op=11: reg <= 0.
  - Exactly one register changes per cycle.
- wrap is asserted for the next cycle only when:
  - op=01 and the old value is all-ones (result 0), or
  - op=10 and the old value is 0 (result all-ones).
  - Otherwise wrap=0, including when wrEn=0 or the address is invalid.
- wrAddr>=DEPTH: the write is ignored, no state changes, and wrap=0.
- Reads:
  - One-cycle latency: the address applied before posedge N yields data valid after posedge N.
  - Both ports are independent; they may share an address with each other and with the write port.
  - rdAddr>=DEPTH returns 0 (zeroA=1 for port A).
- Read/write collision (rdAddr == wrAddr, valid write in the same cycle):
  - BYPASS=1: output equals the value written this cycle (the op result).
  - BYPASS=0: output equals the value held before this cycle's write.
- wrEn=0: all registers hold; read ports keep updating from their addresses every cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=1 for 1 cycle with RESET_VAL=0 -> all 8 registers read 0 on both ports, zeroA=1, wrap=0. Then assert rst together with wrEn=1, op=00, dataIn=43 -> the write is discarded and the register still reads 0.
- Load/read: load reg2=20 and reg5=43 (WIDTH=12). Set rdAddrA=2, rdAddrB=5 -> one cycle later dataOutA=20, dataOutB=43, zeroA=0. With wrEn=0 for 5 cycles, the values persist.
- Increment wrap: load reg3=4094, then op=01 three times -> successive values 4095, 0 (wrap=1 for exactly one cycle), 1. Decrement reg3 from 1 with op=10 twice -> values 0, then 4095 with wrap=1.
- Clear and invalid address (DEPTH=6 build): op=11 on reg1 holding 7 -> reg1 reads 0, zeroA=1. A write to wrAddr=7 with dataIn=99 -> no register changes, and a read of address 7 returns 0.
- Collision: reg4=10; in the same cycle issue op=01 on reg4 with rdAddrA=rdAddrB=4. Required output: dataOutA=dataOutB=11 with BYPASS=1, or 10 with BYPASS=0. The next cycle reads 11 in both builds.
- Random soak: 1000 cycles of randomized rst, wrEn, op, addresses and dataIn, checked against a reference model of DEPTH registers, including the wrap pulse and zeroA.
